// File: rtl/rv32_alu_imm_unit_if.sv
// rtl/rv32_alu_imm_unit_if.sv - execute-stage operand/result bundle for the ALU and immediate decoder
interface rv32_alu_imm_unit_if;
    logic [31:0] instr;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] imm;
    logic [31:0] result;
    logic        take_b;

    modport master (
        output instr,
        output in_a,
        output in_b,
        input  imm,
        input  result,
        input  take_b
    );

    modport slave (
        input  instr,
        input  in_a,
        input  in_b,
        output imm,
        output result,
        output take_b
    );
endinterface

// File: rtl/rv32_alu_imm_unit.sv
// rtl/rv32_alu_imm_unit.sv - RV32I execute support: reset conditioner, immediate decoder, integer ALU
module rv32_alu_imm_unit #(
    parameter int RST_HOLD = 2
) (
    input  logic                      CLK,
    input  logic                      RESET,
    output logic                      clk,
    output logic                      resetn,
    rv32_alu_imm_unit_if.slave        bus
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [7:0] HOLD = 8'(RST_HOLD);

    logic [7:0] rst_cnt;
    logic [7:0] rst_cnt_next;

    assign clk = CLK;

    // resetn is a flop so the core never sees a combinational glitch from the counter compare
    always_comb begin
        rst_cnt_next = (rst_cnt == HOLD) ? rst_cnt : rst_cnt + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rst_cnt <= 8'd0;
            resetn  <= 1'b0;
        end else begin
            rst_cnt <= rst_cnt_next;
            resetn  <= (rst_cnt_next == HOLD);
        end
    end

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        f7b;

    assign instr  = bus.instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7b    = instr[30];

    always_comb begin
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR:
                bus.imm = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                bus.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                bus.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                bus.imm = {instr[31:12], 12'b0};
            OPC_JAL:
                bus.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                bus.imm = 32'd0;
        endcase
    end

    logic [31:0]        a;
    logic [31:0]        b;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic [4:0]         shamt;
    logic               is_op;
    logic               is_alu;

    assign a      = bus.in_a;
    assign b      = bus.in_b;
    assign a_s    = bus.in_a;
    assign b_s    = bus.in_b;
    assign shamt  = bus.in_b[4:0];
    assign is_op  = (opcode == OPC_OP);
    assign is_alu = is_op || (opcode == OPC_OP_IMM);

    // Non-ALU opcodes fall through to a plain add; the pipeline uses it for PC+4 and AUIPC
    always_comb begin
        bus.result = a + b;
        if (is_alu) begin
            case (f3)
                3'b000:  bus.result = (is_op && f7b) ? a - b : a + b;
                3'b001:  bus.result = a << shamt;
                3'b010:  bus.result = {31'd0, a_s < b_s};
                3'b011:  bus.result = {31'd0, a < b};
                3'b100:  bus.result = a ^ b;
                3'b101:  bus.result = f7b ? 32'(a_s >>> shamt) : a >> shamt;
                3'b110:  bus.result = a | b;
                default: bus.result = a & b;
            endcase
        end
    end

    always_comb begin
        bus.take_b = 1'b0;
        if (opcode == OPC_BRANCH) begin
            case (f3)
                3'b000:  bus.take_b = (a == b);
                3'b001:  bus.take_b = (a != b);
                3'b100:  bus.take_b = (a_s < b_s);
                3'b101:  bus.take_b = (a_s >= b_s);
                3'b110:  bus.take_b = (a < b);
                3'b111:  bus.take_b = (a >= b);
                default: bus.take_b = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_alu_imm_unit.sv
// tb/tb_rv32_alu_imm_unit.sv - self-checking bench for rv32_alu_imm_unit
module tb_rv32_alu_imm_unit;

    localparam int RST_HOLD = 2;

    logic CLK;
    logic RESET;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    rv32_alu_imm_unit_if bus_if ();

    rv32_alu_imm_unit #(.RST_HOLD(RST_HOLD)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] op);
        return {imm, 5'd1, f3, 5'd2, op};
    endfunction

    function automatic logic [31:0] enc_s(input int off);
        logic [11:0] v;
        v = off[11:0];
        return {v[11:5], 5'd3, 5'd1, 3'b010, v[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int off, input logic [2:0] f3);
        logic [12:0] v;
        v = off[12:0];
        return {v[12], v[10:5], 5'd3, 5'd1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] up, input logic [6:0] op);
        return {up, 5'd1, op};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] v;
        v = off[20:0];
        return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Reference immediate: field values weighted by their bit position, sign bit negative
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        longint v;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                v = longint'(i[30:20]) + (i[31] ? -2048 : 0);
            7'b0100011:
                v = longint'(i[30:25]) * 32 + longint'(i[11:7]) + (i[31] ? -2048 : 0);
            7'b1100011:
                v = (i[31] ? -4096 : 0) + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                    + longint'(i[11:8]) * 2;
            7'b0110111, 7'b0010111:
                v = longint'(i[31:12]) * 4096;
            7'b1101111:
                v = (i[31] ? -1048576 : 0) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                    + longint'(i[30:21]) * 2;
            default:
                v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, sa, sb, p, v;
        int sh;
        la = longint'(a);
        lb = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        p  = longint'(1) << sh;
        v  = la + lb;
        if (i[6:0] == 7'b0110011 || i[6:0] == 7'b0010011) begin
            case (i[14:12])
                3'd0: v = (i[6:0] == 7'b0110011 && i[30]) ? la - lb : la + lb;
                3'd1: v = la * p;
                3'd2: v = (sa < sb) ? 1 : 0;
                3'd3: v = (la < lb) ? 1 : 0;
                3'd4: v = longint'(a ^ b);
                3'd5: v = !i[30] ? la / p : (sa >= 0 ? sa / p : -((-sa + p - 1) / p));
                3'd6: v = longint'(a | b);
                3'd7: v = longint'(a & b);
            endcase
        end
        return 32'(v);
    endfunction

    function automatic logic ref_take(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, sa, sb;
        la = longint'(a);
        lb = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (i[6:0] != 7'b1100011) return 1'b0;
        case (i[14:12])
            3'd0: return la == lb;
            3'd1: return la != lb;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return la < lb;
            3'd7: return la >= lb;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        bus_if.instr = i;
        bus_if.in_a  = a;
        bus_if.in_b  = b;
        #1;
    endtask

    logic [6:0] opc_tbl [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
                                 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1110011,
                                 7'b0110011, 7'b0010011};

    initial begin
        int released;
        logic [31:0] ri, ra, rb;
        checks = 0;
        errors = 0;
        RESET = 1'b1;
        bus_if.instr = 32'd0;
        bus_if.in_a  = 32'd0;
        bus_if.in_b  = 32'd0;

        repeat (3) begin
            @(negedge CLK);
            chk("resetn_held", {31'd0, resetn}, 32'd0);
        end
        RESET = 1'b0;
        released = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            released++;
            chk($sformatf("resetn_release_%0d", released), {31'd0, resetn},
                {31'd0, released >= RST_HOLD});
        end
        RESET = 1'b1;
        @(negedge CLK);
        chk("resetn_reassert", {31'd0, resetn}, 32'd0);
        #2;
        chk("clk_low", {31'd0, clk}, 32'd0);
        #5;
        chk("clk_high", {31'd0, clk}, 32'd1);

        drive(32'hFFF00093, 32'd0, 32'd0);
        chk("imm_addi_in_reset", bus_if.imm, 32'hFFFFFFFF);
        @(negedge CLK);
        RESET = 1'b0;

        drive(enc_s(-4), 32'd0, 32'd0);
        chk("imm_sw_m4", bus_if.imm, 32'hFFFFFFFC);
        drive(enc_b(8, 3'd0), 32'd0, 32'd0);
        chk("imm_beq_8", bus_if.imm, 32'h00000008);
        drive(enc_u(20'h12345, 7'b0110111), 32'd0, 32'd0);
        chk("imm_lui", bus_if.imm, 32'h12345000);
        drive(enc_j(-2048), 32'd0, 32'd0);
        chk("imm_jal_m2048", bus_if.imm, 32'hFFFFF800);
        drive(32'h00000033, 32'd0, 32'd0);
        chk("imm_add_zero", bus_if.imm, 32'd0);

        drive(enc_r(7'h20, 3'd0), 32'd5, 32'd7);
        chk("sub", bus_if.result, 32'hFFFFFFFE);
        drive(enc_r(7'h20, 3'd5), 32'h80000000, 32'd4);
        chk("sra", bus_if.result, 32'hF8000000);
        drive(enc_r(7'h00, 3'd5), 32'h80000000, 32'd4);
        chk("srl", bus_if.result, 32'h08000000);
        drive(enc_r(7'h00, 3'd2), 32'hFFFFFFFF, 32'd1);
        chk("slt", bus_if.result, 32'd1);
        drive(enc_r(7'h00, 3'd3), 32'hFFFFFFFF, 32'd1);
        chk("sltu", bus_if.result, 32'd0);
        drive(enc_r(7'h00, 3'd1), 32'h00000003, 32'hFFFFFFE4);
        chk("sll_5bit_shamt", bus_if.result, 32'h00000030);
        drive(enc_i(12'h400, 3'd0, 7'b0010011), 32'd1, 32'h400);
        chk("addi_bit30", bus_if.result, 32'h00000401);

        drive(enc_b(8, 3'd4), 32'hFFFFFFFF, 32'd0);
        chk("blt", {31'd0, bus_if.take_b}, 32'd1);
        drive(enc_b(8, 3'd6), 32'hFFFFFFFF, 32'd0);
        chk("bltu", {31'd0, bus_if.take_b}, 32'd0);
        drive(enc_b(8, 3'd7), 32'hFFFFFFFF, 32'd0);
        chk("bgeu", {31'd0, bus_if.take_b}, 32'd1);
        drive(enc_b(8, 3'd1), 32'h1234, 32'h1234);
        chk("bne_equal", {31'd0, bus_if.take_b}, 32'd0);
        drive(enc_b(8, 3'd2), 32'd1, 32'd2);
        chk("branch_f3_010", {31'd0, bus_if.take_b}, 32'd0);
        drive(enc_r(7'h00, 3'd0), 32'd9, 32'd9);
        chk("add_no_take", {31'd0, bus_if.take_b}, 32'd0);

        drive(enc_j(16), 32'h100, 32'd4);
        chk("jal_pc4", bus_if.result, 32'h00000104);
        drive(enc_u(20'h00001, 7'b0010111), 32'h200, 32'h1000);
        chk("auipc", bus_if.result, 32'h00001200);

        for (int n = 0; n < 300; n++) begin
            ri = $urandom;
            ri[6:0] = opc_tbl[$urandom_range(0, 11)];
            ra = $urandom;
            rb = (n % 4 == 0) ? ra : $urandom;
            drive(ri, ra, rb);
            chk($sformatf("rnd%0d_imm i=%h", n, ri), bus_if.imm, ref_imm(ri));
            chk($sformatf("rnd%0d_res i=%h a=%h b=%h", n, ri, ra, rb), bus_if.result, ref_alu(ri, ra, rb));
            chk($sformatf("rnd%0d_tkb i=%h a=%h b=%h", n, ri, ra, rb), {31'd0, bus_if.take_b},
                {31'd0, ref_take(ri, ra, rb)});
        end

        @(negedge CLK);
        chk("resetn_after_run", {31'd0, resetn}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_alu_imm_unit.md
Name: rv32_alu_imm_unit

Overview:
- Execute-stage support block for the RV32I 5-stage pipelined core.
- Contains three parts:
  - a clock/reset conditioner that turns board CLK/RESET into the core's clk/resetn;
  - an immediate decoder that builds the sign-extended immediate from the instruction;
  - an integer ALU that computes the result and the branch-taken flag.
- Immediate decoder and ALU are purely combinational. Only the reset conditioner holds state.

Parameters:
- RST_HOLD, default 2: number of CLK cycles resetn stays low after RESET is sampled low (legal range 1..255).

Ports:
- CLK, input, 1: board clock; the only clock.
- RESET, input, 1: reset. Synchronous, active-high.
- clk, output, 1: core clock. Direct pass-through of CLK, no division.
- resetn, output, 1: active-low reset to the core. Registered on CLK.
- instr, input, 32: instruction in the execute stage (de_IR).
- in_a, input, 32: ALU operand 1 (rs1 or PC).
- in_b, input, 32: ALU operand 2 (rs2, immediate, or constant 4).
- imm, output, 32: decoded, sign-extended immediate of instr.
- result, output, 32: ALU result.
- take_b, output, 1: branch condition true.

Behaviour:
- Reset conditioner
  - 8-bit counter clocked on CLK rising edge.
  - While RESET=1: counter is cleared to 0 and resetn=0.
  - While RESET=0: counter increments, saturating at RST_HOLD; resetn=1 exactly when counter==RST_HOLD.
  - After RESET falls, resetn rises on the RST_HOLD-th rising edge at which RESET=0 is sampled.
  - RESET asserted mid-run: resetn=0 from the next edge.
  - No asynchronous paths; clk = CLK combinationally.
- Immediate decode (opcode = instr[6:0])
  - I-type (0000011 load, 0010011 OP-IMM, 1100111 JALR): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U-type (0110111 LUI, 0010111 AUIPC): {instr[31:12], 12'b0}.
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - Any other opcode (OP, SYSTEM, illegal): 0.
- ALU result (f3 = instr[14:12], f7b = instr[30])
  - Opcode 0110011 (OP) or 0010011 (OP-IMM), by f3:
    - 000: add; subtract only when OP and f7b=1 (ADDI never subtracts).
    - 001: in_a << in_b[4:0].
    - 010: signed in_a < in_b → 1, else 0.
    - 011: unsigned compare, same form.
    - 100: xor.
    - 101: f7b=1 → arithmetic right shift by in_b[4:0]; f7b=0 → logical right shift. Applies to both OP and OP-IMM.
    - 110: or.
    - 111: and.
  - Every other opcode (JAL, JALR, AUIPC, load, store, branch, LUI, system): result = in_a + in_b, mod 2^32. The core relies on this for PC+4 and AUIPC.
- take_b
  - Only for opcode 1100011, by f3:
    - 000: equal.
    - 001: not equal.
    - 100: signed <.
    - 101: signed >=.
    - 110: unsigned <.
    - 111: unsigned >=.
    - 010/011: 0.
  - take_b = 0 for all non-branch opcodes.
- Arithmetic wraps with no overflow flag. Shift amounts use only 5 bits; upper bits of in_b are ignored.
- Combinational outputs respond in the same cycle and are unaffected by RESET.

Test Plan:
- Reset timing, RST_HOLD=2: RESET=1 for 3 cycles, then 0 → resetn=0 throughout, goes 1 on the 2nd edge after release. Re-assert RESET → resetn=0 after the next edge. clk tracks CLK at all times.
- Immediate decode:
  - ADDI x1,x0,-1 (0xFFF00093) → imm=0xFFFFFFFF.
  - SW with offset -4 → imm=0xFFFFFFFC.
  - BEQ offset +8 → imm=8.
  - LUI 0x12345 → imm=0x12345000.
  - JAL offset -2048 → imm=0xFFFFF800.
  - ADD (0x00000033) → imm=0.
- ALU OP group:
  - SUB with in_a=5, in_b=7 → 0xFFFFFFFE.
  - SRA with in_a=0x80000000, in_b=4 → 0xF8000000.
  - SRL with the same operands → 0x08000000.
  - SLT with in_a=-1, in_b=1 → 1.
  - SLTU with the same operands → 0.
- ADDI with instr[30]=1 (imm bit 10 set), in_a=1, in_b=0x400 → result 0x401, never a subtraction.
- Branches:
  - BLT with in_a=0xFFFFFFFF, in_b=0 → take_b=1.
  - BLTU with the same operands → 0.
  - BGEU with the same operands → 1.
  - BNE with equal operands → 0.
  - take_b=0 for f3=010 and for any ADD instruction.
- Default add: JAL with in_a=0x100, in_b=4 → result 0x104. AUIPC with in_a=0x200, in_b=0x1000 → result 0x1200.
